// File: rtl/video_pattern_source_if.sv
// Request/response FIFO ports shared by a scaler pipeline and its upstream
// pattern source; master is the source side that pops requests and pushes pixels.
interface video_pattern_source_if #(
    parameter int CHUNK_BITS = 5
);
    localparam int REQUEST_BITS = 11 + (11 - CHUNK_BITS);

    // Handshake: a request is consumed on a rising edge where
    // requestFifoReadEnable is high (only legal while requestFifoEmpty is low);
    // a pixel is transferred on a rising edge where responseFifoWriteEnable is high
    // (only legal while responseFifoFull is low). Read data is show-ahead.
    logic                    requestFifoReadEnable;
    logic                    requestFifoEmpty;
    logic [REQUEST_BITS-1:0] requestFifoReadData;
    logic                    responseFifoWriteEnable;
    logic                    responseFifoFull;
    logic [15:0]             responseFifoWriteData;

    modport master (
        output requestFifoReadEnable,
        input  requestFifoEmpty,
        input  requestFifoReadData,
        output responseFifoWriteEnable,
        input  responseFifoFull,
        output responseFifoWriteData
    );

    modport slave (
        input  requestFifoReadEnable,
        output requestFifoEmpty,
        output requestFifoReadData,
        input  responseFifoWriteEnable,
        output responseFifoFull,
        input  responseFifoWriteData
    );
endinterface

// File: rtl/video_pattern_source.sv
// Answers scaler chunk requests with CHUNK_SIZE pixels of a synthesized RGB565 pattern.
// Optional frame border/clipping enabled by defining VIDEO_PATTERN_SOURCE_BORDER_EN.
module video_pattern_source #(
    parameter  int CHUNK_BITS     = 5,
    localparam int HACTIVE_BITS   = 11,
    localparam int VACTIVE_BITS   = 11,
    localparam int CHUNKNUM_BITS  = HACTIVE_BITS - CHUNK_BITS,
    localparam int REQUEST_BITS   = VACTIVE_BITS + CHUNKNUM_BITS,
    localparam int BITS_PER_PIXEL = 16
) (
    input  logic                      scalerClock,
    input  logic                      reset,
    input  logic [1:0]                patternMode,
    input  logic [BITS_PER_PIXEL-1:0] solidColor,
    input  logic [3:0]                barShift,
    input  logic [VACTIVE_BITS-1:0]   frameRows,
    input  logic [HACTIVE_BITS-1:0]   frameColumns,
    video_pattern_source_if.master    bus,
    output logic [0:0]                debug_state_o
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    localparam logic [CHUNK_BITS-1:0] IDX_ONE  = 1;
    localparam logic [CHUNK_BITS-1:0] IDX_LAST = '1;

    logic [0:0]                state_q, state_d;
    logic [CHUNK_BITS-1:0]     pixel_index_q, pixel_index_d;
    logic [VACTIVE_BITS-1:0]   row_q, row_d;
    logic [CHUNKNUM_BITS-1:0]  chunk_q, chunk_d;
    logic [1:0]                mode_q, mode_d;
    logic [BITS_PER_PIXEL-1:0] solid_q, solid_d;
    logic [3:0]                bar_shift_q, bar_shift_d;
`ifdef VIDEO_PATTERN_SOURCE_BORDER_EN
    logic [VACTIVE_BITS-1:0]   frame_rows_q, frame_rows_d;
    logic [HACTIVE_BITS-1:0]   frame_cols_q, frame_cols_d;
`endif

    logic                      read_en;
    logic                      write_en;
    logic [HACTIVE_BITS-1:0]   col;
    logic [HACTIVE_BITS-1:0]   bar_raw;
    logic [2:0]                bar_idx;
    logic [BITS_PER_PIXEL-1:0] pattern_px;
    logic [BITS_PER_PIXEL-1:0] pixel;

    always_comb begin
        state_d       = state_q;
        pixel_index_d = pixel_index_q;
        row_d         = row_q;
        chunk_d       = chunk_q;
        mode_d        = mode_q;
        solid_d       = solid_q;
        bar_shift_d   = bar_shift_q;
`ifdef VIDEO_PATTERN_SOURCE_BORDER_EN
        frame_rows_d  = frame_rows_q;
        frame_cols_d  = frame_cols_q;
`endif
        read_en       = 1'b0;
        write_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.requestFifoEmpty) begin
                    read_en       = 1'b1;
                    row_d         = bus.requestFifoReadData[REQUEST_BITS-1 -: VACTIVE_BITS];
                    chunk_d       = bus.requestFifoReadData[CHUNKNUM_BITS-1:0];
                    mode_d        = patternMode;
                    solid_d       = solidColor;
                    bar_shift_d   = barShift;
`ifdef VIDEO_PATTERN_SOURCE_BORDER_EN
                    frame_rows_d  = frameRows;
                    frame_cols_d  = frameColumns;
`endif
                    pixel_index_d = '0;
                    state_d       = EMIT;
                end
            end
            EMIT: begin
                // Backpressure simply freezes the index, so data stays stable while full.
                if (!bus.responseFifoFull) begin
                    write_en = 1'b1;
                    if (pixel_index_q == IDX_LAST) begin
                        pixel_index_d = '0;
                        state_d       = IDLE;
                    end else begin
                        pixel_index_d = pixel_index_q + IDX_ONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        col     = {chunk_q, pixel_index_q};
        bar_raw = col >> bar_shift_q;
        // Saturate so wide columns stay on the last (black) bar instead of wrapping.
        bar_idx = (bar_raw > 11'd7) ? 3'd7 : bar_raw[2:0];
        case (mode_q)
            2'd0: pattern_px = solid_q;
            2'd1: pattern_px = {col[7:3], col[7:2], col[7:3]};
            2'd2: begin
                case (bar_idx)
                    3'd0:    pattern_px = 16'hFFFF;
                    3'd1:    pattern_px = 16'hFFE0;
                    3'd2:    pattern_px = 16'h07FF;
                    3'd3:    pattern_px = 16'h07E0;
                    3'd4:    pattern_px = 16'hF81F;
                    3'd5:    pattern_px = 16'hF800;
                    3'd6:    pattern_px = 16'h001F;
                    default: pattern_px = 16'h0000;
                endcase
            end
            default: pattern_px = (col[3] ^ row_q[3]) ? 16'hFFFF : 16'h0000;
        endcase
        pixel = pattern_px;
`ifdef VIDEO_PATTERN_SOURCE_BORDER_EN
        if ((row_q >= frame_rows_q) || (col >= frame_cols_q)) begin
            pixel = 16'h0000;
        end else if ((row_q == 11'd0) || (row_q == frame_rows_q - 11'd1) ||
                     (col == 11'd0) || (col == frame_cols_q - 11'd1)) begin
            pixel = 16'hFFFF;
        end
`endif
    end

`ifndef VIDEO_PATTERN_SOURCE_BORDER_EN
    logic unused_frame_cfg;
    assign unused_frame_cfg = ^{frameRows, frameColumns, row_q};
`endif

    always_ff @(posedge scalerClock) begin
        if (reset) begin
            state_q       <= IDLE;
            pixel_index_q <= '0;
            row_q         <= '0;
            chunk_q       <= '0;
            mode_q        <= '0;
            solid_q       <= '0;
            bar_shift_q   <= '0;
`ifdef VIDEO_PATTERN_SOURCE_BORDER_EN
            frame_rows_q  <= '0;
            frame_cols_q  <= '0;
`endif
        end else begin
            state_q       <= state_d;
            pixel_index_q <= pixel_index_d;
            row_q         <= row_d;
            chunk_q       <= chunk_d;
            mode_q        <= mode_d;
            solid_q       <= solid_d;
            bar_shift_q   <= bar_shift_d;
`ifdef VIDEO_PATTERN_SOURCE_BORDER_EN
            frame_rows_q  <= frame_rows_d;
            frame_cols_q  <= frame_cols_d;
`endif
        end
    end

    // Strobes are gated by reset so nothing is popped or pushed while resetting.
    assign bus.requestFifoReadEnable   = read_en & ~reset;
    assign bus.responseFifoWriteEnable = write_en & ~reset;
    assign bus.responseFifoWriteData   = (state_q == EMIT) ? pixel : 16'h0000;
    assign debug_state_o               = state_q;
endmodule

// File: tb/tb_video_pattern_source.sv
// Randomized scoreboard bench for video_pattern_source against a behavioural pattern model.
// Border checks compile in when VIDEO_PATTERN_SOURCE_BORDER_EN is defined.
module tb_video_pattern_source;
  localparam int CHUNK_BITS = 5;
  localparam int CHUNK_SIZE = 1 << CHUNK_BITS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  cfg_mode = 2'd0;
  logic [15:0] cfg_solid = 16'h0000;
  logic [3:0]  cfg_shift = 4'd0;
  logic [10:0] cfg_rows = 11'd480;
  logic [10:0] cfg_cols = 11'd640;
  logic [0:0]  dbg_state;

  video_pattern_source_if #(.CHUNK_BITS(CHUNK_BITS)) bus ();

  video_pattern_source #(.CHUNK_BITS(CHUNK_BITS)) dut (
    .scalerClock  (clk),
    .reset        (rst),
    .patternMode  (cfg_mode),
    .solidColor   (cfg_solid),
    .barShift     (cfg_shift),
    .frameRows    (cfg_rows),
    .frameColumns (cfg_cols),
    .bus          (bus),
    .debug_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cycle_cnt = 0;
  int          wr_count = 0;
  int          acc_cnt = 0;
  int          wr_ptr = 0;
  int          full_mode = 0;
  logic [16:0] req_mem [0:1023];
  logic [15:0] exp_q[$];
  int          accept_cyc[$];

  // ---------------- reference model ----------------
  function automatic int bar_color(input int idx);
    case (idx)
      0: return 'hFFFF;
      1: return 'hFFE0;
      2: return 'h07FF;
      3: return 'h07E0;
      4: return 'hF81F;
      5: return 'hF800;
      6: return 'h001F;
      default: return 'h0000;
    endcase
  endfunction

  function automatic logic [15:0] model_pixel(input int row, input int col, input int mode,
                                              input int solid, input int shift,
                                              input int frows, input int fcols);
    int g;
    int bar;
    int p;
    case (mode)
      0: p = solid;
      1: begin
        g = col % 256;
        p = (g / 8) * 2048 + (g / 4) * 32 + (g / 8);
      end
      2: begin
        bar = col / (1 << shift);
        if (bar > 7) bar = 7;
        p = bar_color(bar);
      end
      default: p = (((col / 8) % 2) != ((row / 8) % 2)) ? 'hFFFF : 0;
    endcase
`ifdef VIDEO_PATTERN_SOURCE_BORDER_EN
    if (row >= frows || col >= fcols) p = 0;
    else if (row == 0 || row == frows - 1 || col == 0 || col == fcols - 1) p = 'hFFFF;
`else
    if (frows < 0 || fcols < 0) p = 0;
`endif
    return p[15:0];
  endfunction

  // ---------------- FSM-free FIFO driver ----------------
  always @(posedge clk) begin
    #1;
    case (full_mode)
      1: bus.responseFifoFull = ~bus.responseFifoFull;
      2: bus.responseFifoFull = ($urandom_range(0, 3) == 0);
      default: bus.responseFifoFull = 1'b0;
    endcase
    bus.requestFifoEmpty    = (acc_cnt == wr_ptr);
    bus.requestFifoReadData = (acc_cnt == wr_ptr) ? 17'd0 : req_mem[acc_cnt];
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [15:0] exp_px;
    int          row;
    int          chunk;
    cycle_cnt++;
    if (rst) begin
      checks++;
      if (bus.responseFifoWriteEnable || bus.requestFifoReadEnable)
        $display("FAIL reset_quiet: we=%0b re=%0b required 0 0",
                 bus.responseFifoWriteEnable, bus.requestFifoReadEnable);
      if (bus.responseFifoWriteEnable || bus.requestFifoReadEnable) errors++;
      exp_q.delete();
    end else begin
      if (exp_q.size() == 0) begin
        checks++;
        if (bus.responseFifoWriteEnable || bus.responseFifoWriteData != 16'h0000) begin
          errors++;
          $display("FAIL idle_outputs: we=%0b data=%h required we=0 data=0000 (cycle %0d)",
                   bus.responseFifoWriteEnable, bus.responseFifoWriteData, cycle_cnt);
        end
      end else begin
        if (bus.responseFifoFull) begin
          checks++;
          if (bus.responseFifoWriteEnable) begin
            errors++;
            $display("FAIL write_while_full: we=1 required 0 (cycle %0d)", cycle_cnt);
          end
        end else begin
          checks++;
          if (!bus.responseFifoWriteEnable) begin
            errors++;
            $display("FAIL missing_write: we=0 required 1 (cycle %0d)", cycle_cnt);
          end
        end
        if (bus.responseFifoWriteEnable && !bus.responseFifoFull) begin
          exp_px = exp_q.pop_front();
          wr_count++;
          checks++;
          if (bus.responseFifoWriteData !== exp_px) begin
            errors++;
            $display("FAIL pixel_data: got %h required %h (cycle %0d)",
                     bus.responseFifoWriteData, exp_px, cycle_cnt);
          end
        end
      end
      if (bus.requestFifoReadEnable) begin
        checks++;
        if (bus.requestFifoEmpty) begin
          errors++;
          $display("FAIL pop_when_empty: re=1 with empty=1 (cycle %0d)", cycle_cnt);
        end else begin
          if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pop_mid_chunk: re=1 with %0d pixels outstanding required 0",
                     exp_q.size());
          end
          row   = int'(bus.requestFifoReadData[16:6]);
          chunk = int'(bus.requestFifoReadData[5:0]);
          for (int i = 0; i < CHUNK_SIZE; i++)
            exp_q.push_back(model_pixel(row, chunk * CHUNK_SIZE + i, int'(cfg_mode),
                                        int'(cfg_solid), int'(cfg_shift),
                                        int'(cfg_rows), int'(cfg_cols)));
          accept_cyc.push_back(cycle_cnt);
          acc_cnt++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_req(input int row, input int chunk);
    req_mem[wr_ptr] = {row[10:0], chunk[5:0]};
    wr_ptr++;
  endtask

  task automatic set_cfg(input int mode, input int solid, input int shift);
    cfg_mode  = mode[1:0];
    cfg_solid = solid[15:0];
    cfg_shift = shift[3:0];
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (n < 4000 && !(acc_cnt == wr_ptr && exp_q.size() == 0)) begin
      @(posedge clk);
      #2;
      n++;
    end
    repeat (3) begin
      @(posedge clk);
      #2;
    end
    checks++;
    if (n >= 4000) begin
      errors++;
      $display("FAIL drain_%s: %0d pixels, %0d requests pending after timeout required 0 0",
               name, exp_q.size(), wr_ptr - acc_cnt);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    int target;
    int n;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #2;
    end

    // solid colour single chunk
    set_cfg(0, 'h1234, 0);
    push_req(0, 0);
    drain("solid");

    // colour bars, back-to-back chunks, 33-cycle cadence
    set_cfg(2, 0, 5);
    base = accept_cyc.size();
    for (int k = 0; k < 8; k++) push_req(10, k);
    drain("bars");
    for (int k = 1; k < 8; k++) begin
      checks++;
      if (accept_cyc[base + k] - accept_cyc[base + k - 1] != CHUNK_SIZE + 1) begin
        errors++;
        $display("FAIL chunk_period: got %0d cycles required %0d",
                 accept_cyc[base + k] - accept_cyc[base + k - 1], CHUNK_SIZE + 1);
      end
    end

    // checkerboard
    set_cfg(3, 0, 0);
    push_req(8, 0);
    drain("checker");

    // gray ramp under alternating backpressure
    set_cfg(1, 0, 0);
    full_mode = 1;
    push_req(2, 3);
    drain("gray_bp");
    full_mode = 0;

    // reset after 10 pixels, then restart
    set_cfg(0, 'hBEEF, 0);
    target = wr_count + 10;
    push_req(3, 1);
    n = 0;
    while (wr_count < target && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    checks++;
    if (wr_count != target) begin
      errors++;
      $display("FAIL reset_setup: writes %0d required %0d", wr_count, target);
    end
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #2;
    end
    rst = 1'b0;
    set_cfg(2, 0, 2);
    push_req(4, 0);
    drain("after_reset");

`ifdef VIDEO_PATTERN_SOURCE_BORDER_EN
    cfg_rows = 11'd480;
    cfg_cols = 11'd640;
    set_cfg(0, 'h1234, 0);
    push_req(0, 1);
    push_req(5, 0);
    push_req(5, 20);
    push_req(5, 19);
    push_req(479, 2);
    drain("border");
`endif

    // randomized requests with random config changes and backpressure
    full_mode = 2;
    for (int i = 0; i < 40; i++)
      push_req($urandom_range(0, 2047), $urandom_range(0, 63));
    n = 0;
    while (n < 4000 && !(acc_cnt == wr_ptr && exp_q.size() == 0)) begin
      set_cfg($urandom_range(0, 3), $urandom_range(0, 65535), $urandom_range(0, 9));
      @(posedge clk);
      #2;
      n++;
    end
    full_mode = 0;
    drain("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
